// File: rtl/heston_pkg.sv
// Shared Q8.24 constants, path-engine state encoding and helpers for the Heston blocks.
package heston_pkg;

  localparam int          Q_FRAC = 24;
  localparam logic [31:0] Q_ONE  = 32'h0100_0000;

  typedef logic [0:0] state_t;
  localparam state_t S_ACC  = 1'b0;
  localparam state_t S_WAIT = 1'b1;

  // Mean of num_sum uniforms in [0,1): num_sum/2 in Q8.24.
  function automatic logic [31:0] clt_offset(input int num_sum);
    clt_offset = 32'(num_sum) << (Q_FRAC - 1);
  endfunction

endpackage

// File: rtl/gauss_clt_q8_24.sv
// Central-limit normal generator: sums NUM_SUM uniform Q8.24 samples, removes the mean,
// and hands the result downstream through valid/ready with a one-deep pending slot.
module gauss_clt_q8_24
  import heston_pkg::*;
#(
  parameter int NUM_SUM   = 12,
  parameter int CNT_W     = 4,
  parameter int OUT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [31:0]          rand_in,
  output logic                 rng_en,
  output logic [31:0]          z_out,
  output logic                 z_valid,
  input  logic                 z_ready,
  output logic [OUT_CNT_W-1:0] n_delivered
);

  localparam logic [31:0]      OFFSET   = clt_offset(NUM_SUM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SUM - 1);

  state_t                 r_state;
  logic signed [31:0]     r_acc;
  logic [CNT_W-1:0]       r_cnt;
  logic [31:0]            r_pending;
  logic [31:0]            r_z_out;
  logic                   r_z_valid;
  logic [OUT_CNT_W-1:0]   r_n_delivered;

  logic                   w_rng_en;
  logic signed [31:0]     w_acc_next;
  logic [31:0]            w_result;
  logic                   w_last;
  logic                   w_xfer;
  logic                   w_slot_free;
  logic                   w_unused_upper;

  assign w_rng_en       = (r_state == S_ACC) && en && !reset;
  assign w_acc_next     = r_acc + $signed({8'b0, rand_in[23:0]});
  assign w_result       = w_acc_next - OFFSET;
  assign w_last         = (r_cnt == CNT_LAST);
  assign w_xfer         = r_z_valid && z_ready;
  assign w_slot_free    = !r_z_valid || z_ready;
  // The RNG integer byte is always zero for [0,1) samples; it is deliberately ignored.
  assign w_unused_upper = ^rand_in[31:24];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_ACC;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_pending     <= '0;
      r_z_out       <= '0;
      r_z_valid     <= 1'b0;
      r_n_delivered <= '0;
    end else begin
      if (w_xfer) begin
        r_n_delivered <= r_n_delivered + 1'b1;
        r_z_valid     <= 1'b0;
      end

      case (r_state)
        S_ACC: begin
          if (w_rng_en) begin
            if (!w_last) begin
              r_acc <= w_acc_next;
              r_cnt <= r_cnt + 1'b1;
            end else begin
              r_acc <= '0;
              r_cnt <= '0;
              if (w_slot_free) begin
                r_z_out   <= w_result;
                r_z_valid <= 1'b1;
              end else begin
                r_pending <= w_result;
                r_state   <= S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          // z_valid is necessarily high here; the pending sample replaces the one being taken.
          if (z_ready) begin
            r_z_out   <= r_pending;
            r_z_valid <= 1'b1;
            r_state   <= S_ACC;
          end
        end
        default: r_state <= S_ACC;
      endcase
    end
  end

  assign rng_en      = w_rng_en;
  assign z_out       = r_z_out;
  assign z_valid     = r_z_valid;
  assign n_delivered = r_n_delivered;

endmodule

// File: tb/tb_gauss_clt_q8_24.sv
// Scoreboard bench for gauss_clt_q8_24: directed streams with hand-computed normal samples.
module tb_gauss_clt_q8_24;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic [31:0] rand_in = 32'h0;
  logic        rng_en;
  logic [31:0] z_out;
  logic        z_valid;
  logic        z_ready = 1'b1;
  logic [15:0] n_delivered;

  gauss_clt_q8_24 #(.NUM_SUM(12), .CNT_W(4), .OUT_CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .rand_in     (rand_in),
    .rng_en      (rng_en),
    .z_out       (z_out),
    .z_valid     (z_valid),
    .z_ready     (z_ready),
    .n_delivered (n_delivered)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_xfer = 0;
  int          consumed = 0;
  logic [31:0] sb[$];
  logic        ramp = 1'b0;
  logic        s_valid, s_rng;
  logic [31:0] s_z;
  logic [15:0] s_ndel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample at negedge, advance the ramp after a consuming edge.
  task automatic tick();
    logic took;
    @(negedge clk);
    s_valid = z_valid;
    s_rng   = rng_en;
    s_z     = z_out;
    s_ndel  = n_delivered;
    took    = rng_en;
    if (took) consumed++;
    @(posedge clk);
    #1;
    if (ramp && took) rand_in = rand_in + 32'd1;
  endtask

  task automatic do_reset();
    chk("leftover_expected", 32'(sb.size()), 32'd0);
    sb.delete();
    reset = 1'b1;
    tick();
    repeat (2) begin
      tick();
      chk("rst_z_valid", {31'b0, s_valid}, 32'd0);
      chk("rst_n_delivered", {16'b0, s_ndel}, 32'd0);
      chk("rst_rng_en", {31'b0, s_rng}, 32'd0);
    end
    reset = 1'b0;
    consumed = 0;
  endtask

  task automatic wait_xfers(input int n, input int budget, output int k);
    k = 0;
    while (n_xfer < n && k < budget) begin
      tick();
      k++;
    end
    chk("xfer_count", 32'(n_xfer), 32'(n));
  endtask

  task automatic latency(output int c);
    c = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (s_valid) break;
      c++;
    end
  endtask

  // Monitor: pops the scoreboard on every transfer and guards output stability under backpressure.
  initial begin
    logic        prev_hold;
    logic [31:0] prev_z;
    logic [31:0] exp;
    prev_hold = 1'b0;
    prev_z    = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        n_xfer    = 0;
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", {31'b0, z_valid}, 32'd1);
          chk("hold_data", z_out, prev_z);
        end
        if (z_valid && z_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_z: got %h expected no transfer (t=%0t)", z_out, $time);
          end else begin
            exp = sb.pop_front();
            chk("z_out", z_out, exp);
            chk("n_delivered", {16'b0, n_delivered}, {16'b0, 16'(n_xfer)});
            $display("xfer %0d: z_out=%h expected=%h", n_xfer, z_out, exp);
          end
          n_xfer++;
        end
        prev_hold = z_valid && !z_ready;
        prev_z    = z_out;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, k, ones;

    // 0.5 constant: mean-centred sum is exactly zero, one sample every 12 cycles.
    rand_in = 32'h0080_0000; en = 1'b1; z_ready = 1'b1; ramp = 1'b0;
    do_reset();
    repeat (3) sb.push_back(32'h0000_0000);
    latency(c);
    chk("first_latency", 32'(c), 32'd12);
    chk("rng_pulses_to_first", 32'(consumed), 32'd13);
    wait_xfers(3, 40, k);
    chk("throughput_cycles", 32'(k), 32'd24);

    // Extremes and masked upper byte.
    rand_in = 32'h0000_0000;
    do_reset();
    repeat (2) sb.push_back(32'hFA00_0000);
    wait_xfers(2, 60, k);

    rand_in = 32'h00FF_FFFF;
    do_reset();
    repeat (2) sb.push_back(32'h05FF_FFF4);
    wait_xfers(2, 60, k);

    rand_in = 32'hAB80_0000;
    do_reset();
    repeat (2) sb.push_back(32'h0000_0000);
    wait_xfers(2, 60, k);

    // Backpressure with a ramping source (low 24 bits count 0,1,2,...).
    rand_in = 32'h0100_0000; ramp = 1'b1; z_ready = 1'b0;
    do_reset();
    sb.push_back(32'hFA00_0042);
    sb.push_back(32'hFA00_00D2);
    sb.push_back(32'hFA00_0162);
    repeat (40) tick();
    chk("wait_consumed", 32'(consumed), 32'd24);
    chk("wait_rng_en", {31'b0, s_rng}, 32'd0);
    chk("wait_z_held", s_z, 32'hFA00_0042);
    z_ready = 1'b1;
    tick();
    z_ready = 1'b0;
    tick();
    chk("pending_valid", {31'b0, s_valid}, 32'd1);
    chk("pending_z", s_z, 32'hFA00_00D2);
    chk("pending_ndel", {16'b0, s_ndel}, 32'd1);
    repeat (29) tick();
    chk("resume_consumed", 32'(consumed), 32'd36);
    z_ready = 1'b1;
    wait_xfers(3, 10, k);

    // Pause after 7 samples; the completed sum must match the uninterrupted one.
    rand_in = 32'h0100_0000; ramp = 1'b1; z_ready = 1'b1; en = 1'b1;
    do_reset();
    sb.push_back(32'hFA00_0042);
    for (int i = 0; i < 20 && consumed < 7; i++) tick();
    en = 1'b0;
    ones = 0;
    repeat (5) begin
      tick();
      if (s_rng) ones++;
    end
    chk("paused_rng_pulses", 32'(ones), 32'd0);
    chk("paused_consumed", 32'(consumed), 32'd7);
    en = 1'b1;
    tick();
    chk("resumed_rng_en", {31'b0, s_rng}, 32'd1);
    wait_xfers(1, 20, k);

    // Reset mid-sum discards the partial accumulation.
    rand_in = 32'h00FF_FFFF; ramp = 1'b0;
    do_reset();
    repeat (5) tick();
    rand_in = 32'h0080_0000;
    do_reset();
    sb.push_back(32'h0000_0000);
    latency(c);
    chk("post_reset_latency", 32'(c), 32'd12);
    wait_xfers(1, 5, k);
    chk("final_leftover", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gauss_clt_q8_24.md
Name: gauss_clt_q8_24

Overview:
- Consumer side of the uniform RNG stream.
- Drives the RNG `en` strobe and sums NUM_SUM uniform Q8.24 samples in [0,1).
- Subtracts the mean, so the output approximates a standard-normal Q8.24 sample (central limit theorem); NUM_SUM=12 gives unit variance.
- Feeds the Heston path engine through a valid/ready output with a one-deep pending buffer.

Parameters:
- NUM_SUM, 12, number of uniforms summed per normal sample (2..16).
- CNT_W, 4, width of the sample counter; must hold NUM_SUM-1.
- OUT_CNT_W, 16, width of the delivered-sample counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  run enable; when 0, accumulation pauses and state is held.
- rand_in  in  32  current RNG register value, Q8.24. Only bits [23:0] are used; bits [31:24] are ignored.
- rng_en  out  1  advance strobe to the RNG. rand_in is consumed in every cycle where rng_en=1.
- z_out  out  32  signed Q8.24 normal sample.
- z_valid  out  1  z_out holds an undelivered sample.
- z_ready  in  1  downstream accepts z_out.
- n_delivered  out  OUT_CNT_W  count of completed z transfers; wraps modulo 2^OUT_CNT_W.

Behaviour:
- Reset: synchronous, active-high. Forces state=ACC, acc=0, cnt=0, pending=0, z_out=0, z_valid=0, n_delivered=0. Asserting reset mid-accumulation discards the partial sum.
- rng_en is combinational:
  - in ACC: rng_en = en && !reset;
  - in WAIT: rng_en = 0.
- Consume rule: in a cycle with rng_en=1, the value rand_in[23:0] is summed. The RNG updates at that edge, so the next cycle presents a fresh value. No sample is used twice or skipped.
- Accumulator: 32-bit signed.
  - acc_next = acc + {8'b0, rand_in[23:0]}.
  - Maximum value is 16*(2^24-1) < 2^31, so there is no overflow.
- OFFSET = NUM_SUM << 23, i.e. NUM_SUM/2 in Q8.24 (0x0600_0000 for 12).
- result = acc_next - OFFSET, in two's complement.
- State ACC:
  - On rng_en with cnt < NUM_SUM-1: acc <= acc_next, cnt <= cnt+1.
  - On rng_en with cnt == NUM_SUM-1: acc <= 0, cnt <= 0.
    - If output slot is free (z_valid==0 or z_ready==1): z_out <= result, z_valid <= 1, stay in ACC.
    - Otherwise: pending <= result, go to WAIT.
- State WAIT:
  - Holds z_out stable and rng_en=0.
  - When z_ready=1: z_out <= pending, z_valid stays 1, go to ACC.
  - en has no effect in WAIT.
- Output handshake:
  - A transfer occurs when z_valid && z_ready.
  - After a transfer with no new load in the same cycle, z_valid <= 0.
  - If a load and a transfer happen in the same cycle, z_valid stays 1 and z_out updates.
  - z_out and z_valid must not change while z_valid=1 && z_ready=0.
- n_delivered increments by 1 on each transfer and wraps from all-ones to 0.
- Latency: with en=1 and z_ready=1 from the first cycle after reset, rng_en is high in cycles 0..NUM_SUM-1. z_valid rises in cycle NUM_SUM (cycle 12 for the default). Sustained throughput is one z every NUM_SUM cycles.
- Output range: [-NUM_SUM/2, +NUM_SUM/2). Upper byte is sign-extended.

Decomposition:
- Shared package `heston_pkg` holds:
  - Q8.24 constants: Q_FRAC=24, Q_ONE=32'h0100_0000;
  - the state typedef {ACC, WAIT};
  - a function computing OFFSET from NUM_SUM.
- No sub-module is needed; a single module of roughly 150 lines.
- Top-level wiring: rng_en connects to the RNG `en`; the RNG output connects to rand_in.

Test Plan:
- Constant rand_in=0x0080_0000 (0.5), en=1, z_ready=1 -> first z_valid at cycle 12, z_out=0x0000_0000; repeats every 12 cycles.
- rand_in=0x0000_0000 -> z_out=0xFA00_0000 (-6.0). rand_in=0x00FF_FFFF -> z_out=0x05FF_FFF4.
- rand_in=0xAB80_0000 (garbage upper byte) -> z_out=0x0000_0000, confirming bits [31:24] are masked.
- Hold z_ready=0 with rand_in=0x0100_0000 ramping by 1 per consumed sample:
  - first z is held stable;
  - the second sum completes and the block enters WAIT, rng_en=0 after exactly 24 consumed samples;
  - pulse z_ready -> pending appears next cycle with z_valid held 1;
  - n_delivered=1, and 12 further rng_en pulses follow.
- Toggle en=0 for 5 cycles mid-sum (after 7 samples), then resume -> result equals the uninterrupted sum; rng_en low exactly while en=0.
- Assert reset after 5 samples, then run rand_in=0x0080_0000 -> z_valid=0 and n_delivered=0 during reset; first z at cycle 12 after release equals 0, with no partial-sum carryover.
